traffic_seq_ctrl: RTL and testbench

- Sequencer for one traffic generator instance at a router injection port.
- Drives the generator's op/data command bus: Init, then Fill per packet descriptor from the host, then one PreDeque, then paced Dequeue.
- Paces Dequeue with a flit-credit counter fed by the router input buffer.
- Reports completion and error status.

---
 rtl/traffic_seq_ctrl_if.sv | 31 +++
 rtl/traffic_seq_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_traffic_seq_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_seq_ctrl_if.sv
// Descriptor handshake, generator command bus and router credit/flit signals
// for traffic_seq_ctrl. The controller attaches through the slave modport.
interface traffic_seq_ctrl_if #(
  parameter int OP_W    = 3,
  parameter int DATA_W  = 32,
  parameter int DEST_W  = 14,
  parameter int VC_W    = 2,
  parameter int NFLIT_W = 10
);
  logic               desc_valid;
  logic               desc_ready;
  logic [DEST_W-1:0]  desc_dest;
  logic [VC_W-1:0]    desc_vc;
  logic [NFLIT_W-1:0] desc_nflit;
  logic [OP_W-1:0]    trf_op;
  logic [DATA_W-1:0]  trf_data;
  logic               credit_ret;
  logic               flit_valid;

  // host / router side
  modport master (
    output desc_valid, desc_dest, desc_vc, desc_nflit, credit_ret,
    input  desc_ready, trf_op, trf_data, flit_valid
  );

  // sequencer side
  modport slave (
    input  desc_valid, desc_dest, desc_vc, desc_nflit, credit_ret,
    output desc_ready, trf_op, trf_data, flit_valid
  );
endinterface

// File: rtl/traffic_seq_ctrl.sv
// Traffic generator sequencer: Init, Fill per descriptor, PreDeque, credit-paced Dequeue.
// Optional RUN statistics counters are enabled by defining TRAFFIC_SEQ_STATS_EN.
module traffic_seq_ctrl #(
  parameter int OP_W    = 3,
  parameter int DATA_W  = 32,
  parameter int DEST_W  = 14,
  parameter int VC_W    = 2,
  parameter int NFLIT_W = 10,
  parameter int PKT_W   = 10,
  parameter int CREDITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  traffic_seq_ctrl_if.slave      bus,
  input  logic                   start,
  input  logic [PKT_W-1:0]       total_pkts,
  output logic                   busy,
  output logic                   done,
  output logic                   err
`ifdef TRAFFIC_SEQ_STATS_EN
  ,
  output logic [31:0]            stat_cycles,
  output logic [31:0]            stat_stalls
`endif
);

  localparam logic [OP_W-1:0] OP_NOP      = OP_W'(0);
  localparam logic [OP_W-1:0] OP_FILL     = OP_W'(1);
  localparam logic [OP_W-1:0] OP_PREDEQUE = OP_W'(2);
  localparam logic [OP_W-1:0] OP_DEQUEUE  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_INIT     = OP_W'(4);

  // generator data field positions
  localparam int NFLIT_LSB = 0;
  localparam int VC_LSB    = NFLIT_W;
  localparam int DEST_LSB  = NFLIT_W + VC_W;
  localparam int TOTAL_LSB = 0;

  localparam int REM_W = PKT_W + NFLIT_W;
  localparam int CRW   = $clog2(CREDITS + 1);
  localparam logic [CRW-1:0] CREDIT_MAX = CRW'(CREDITS);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_FILL, S_PRIME, S_RUN, S_DONE
  } state_t;

  state_t              state, state_n;
  logic [PKT_W-1:0]    pkt_total, pkt_total_d;
  logic [PKT_W-1:0]    pkt_cnt, pkt_cnt_d, pkt_cnt_inc;
  logic [REM_W-1:0]    flit_rem, flit_rem_d;
  logic [CRW-1:0]      credit, credit_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                ready_q, ready_d;
  logic                fv_q, fv_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                hs, deq, start_ok, start_zero, reload;

  assign bus.trf_op     = op_q;
  assign bus.trf_data   = data_q;
  assign bus.desc_ready = ready_q;
  assign bus.flit_valid = fv_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

  assign pkt_cnt_inc = pkt_cnt + 1'b1;
  assign hs          = (state == S_FILL) && bus.desc_valid && ready_q;

  always_comb begin
    state_n     = state;
    op_d        = OP_NOP;
    data_d      = '0;
    pkt_total_d = pkt_total;
    pkt_cnt_d   = pkt_cnt;
    flit_rem_d  = flit_rem;
    err_d       = err_q;
    deq         = 1'b0;
    start_ok    = 1'b0;
    start_zero  = 1'b0;
    reload      = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          start_ok    = 1'b1;
          pkt_total_d = total_pkts;
          pkt_cnt_d   = '0;
          flit_rem_d  = '0;
          if (total_pkts == '0) begin
            state_n    = S_DONE;
            start_zero = 1'b1;
          end else begin
            state_n = S_INIT;
            err_d   = 1'b0;
          end
        end
      end
      S_INIT: begin
        op_d                         = OP_INIT;
        data_d[TOTAL_LSB +: PKT_W]   = pkt_total - 1'b1;
        reload                       = 1'b1;
        state_n                      = S_FILL;
      end
      S_FILL: begin
        if (hs) begin
          pkt_cnt_d = pkt_cnt_inc;
          // zero-flit descriptors are consumed but never reach the generator
          if (bus.desc_nflit != '0) begin
            op_d                         = OP_FILL;
            data_d[DEST_LSB  +: DEST_W]  = bus.desc_dest;
            data_d[VC_LSB    +: VC_W]    = bus.desc_vc;
            data_d[NFLIT_LSB +: NFLIT_W] = bus.desc_nflit;
            flit_rem_d                   = flit_rem + REM_W'(bus.desc_nflit);
          end else begin
            err_d = 1'b1;
          end
          if (pkt_cnt_inc == pkt_total) state_n = S_PRIME;
        end
      end
      S_PRIME: begin
        op_d    = OP_PREDEQUE;
        state_n = S_RUN;
      end
      S_RUN: begin
        if (credit != '0 && flit_rem != '0) begin
          deq        = 1'b1;
          op_d       = OP_DEQUEUE;
          flit_rem_d = flit_rem - 1'b1;
        end else if (flit_rem == '0 && op_q != OP_DEQUEUE) begin
          state_n = S_DONE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    credit_d = credit;
    if (reload) begin
      credit_d = CREDIT_MAX;
    end else if (bus.credit_ret && !deq) begin
      if (credit != CREDIT_MAX) credit_d = credit + 1'b1;
    end else if (!bus.credit_ret && deq) begin
      credit_d = credit - 1'b1;
    end
    if (bus.credit_ret && !deq && credit == CREDIT_MAX) err_d = 1'b1;

    ready_d = (state_n == S_FILL);
    busy_d  = (state_n == S_INIT) || (state_n == S_FILL) ||
              (state_n == S_PRIME) || (state_n == S_RUN);
    // a zero-packet restart from DONE drops done for one cycle
    done_d  = (state_n == S_DONE) && !start_zero;
    fv_d    = (op_q == OP_DEQUEUE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pkt_total <= '0;
      pkt_cnt   <= '0;
      flit_rem  <= '0;
      credit    <= CREDIT_MAX;
      op_q      <= OP_NOP;
      data_q    <= '0;
      ready_q   <= 1'b0;
      fv_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_n;
      pkt_total <= pkt_total_d;
      pkt_cnt   <= pkt_cnt_d;
      flit_rem  <= flit_rem_d;
      credit    <= credit_d;
      op_q      <= op_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      fv_q      <= fv_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

`ifdef TRAFFIC_SEQ_STATS_EN
  logic [31:0] cyc_q, stall_q;

  assign stat_cycles = cyc_q;
  assign stat_stalls = stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q   <= '0;
      stall_q <= '0;
    end else if (start_ok) begin
      cyc_q   <= '0;
      stall_q <= '0;
    end else if (state == S_RUN) begin
      cyc_q <= cyc_q + 1'b1;
      if (flit_rem != '0 && credit == '0) stall_q <= stall_q + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_traffic_seq_ctrl.sv
// Scoreboard bench for traffic_seq_ctrl: stimulus queues expected generator
// commands, a negedge monitor pops and compares every non-NOP op.
module tb_traffic_seq_ctrl;

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_FILL     = 3'd1;
  localparam logic [2:0] OP_PREDEQUE = 3'd2;
  localparam logic [2:0] OP_DEQUEUE  = 3'd3;
  localparam logic [2:0] OP_INIT     = 3'd4;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  total_pkts = '0;
  logic        busy, done, err;
  logic        cr_man = 1'b0;
  logic        auto_ret = 1'b0;
`ifdef TRAFFIC_SEQ_STATS_EN
  logic [31:0] stat_cycles, stat_stalls;
`endif

  int tests = 0;
  int fails = 0;
  int deq_count = 0;
  int fv_count = 0;
  exp_t exp_q[$];

  traffic_seq_ctrl_if bus_if ();

  assign bus_if.credit_ret = cr_man | (auto_ret && bus_if.trf_op == OP_DEQUEUE);

  traffic_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .start      (start),
    .total_pkts (total_pkts),
    .busy       (busy),
    .done       (done),
    .err        (err)
`ifdef TRAFFIC_SEQ_STATS_EN
    ,
    .stat_cycles(stat_cycles),
    .stat_stalls(stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.flit_valid) fv_count++;
      if (bus_if.trf_op != OP_NOP) begin
        if (bus_if.trf_op == OP_DEQUEUE) deq_count++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL op_unexpected: got op %0d data %0h expected none",
                   bus_if.trf_op, bus_if.trf_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (bus_if.trf_op !== e.op ||
              ((e.op == OP_INIT || e.op == OP_FILL) && bus_if.trf_data !== e.data)) begin
            fails++;
            $display("FAIL op_compare: got op %0d data %0h expected op %0d data %0h",
                     bus_if.trf_op, bus_if.trf_data, e.op, e.data);
          end
        end
      end
    end
  end

  function automatic logic [31:0] fill_data(input logic [13:0] d, input logic [1:0] v,
                                            input logic [9:0] n);
    return {6'd0, d, v, n};
  endfunction

  task automatic push(input logic [2:0] op, input logic [31:0] data);
    exp_t e;
    e.op = op;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start(input logic [9:0] n);
    total_pkts = n;
    if (n != 0) push(OP_INIT, {22'd0, n - 10'd1});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_desc(input logic [13:0] d, input logic [1:0] v, input logic [9:0] n);
    int w = 0;
    if (n != 0) push(OP_FILL, fill_data(d, v, n));
    bus_if.desc_dest  = d;
    bus_if.desc_vc    = v;
    bus_if.desc_nflit = n;
    bus_if.desc_valid = 1'b1;
    while (!bus_if.desc_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check("desc_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus_if.desc_valid = 1'b0;
  endtask

  task automatic push_run(input int nflits);
    push(OP_PREDEQUE, 32'd0);
    for (int i = 0; i < nflits; i++) push(OP_DEQUEUE, 32'd0);
  endtask

  task automatic wait_done(input string name, input int budget);
    int w = 0;
    while (!done && w < budget) begin
      @(negedge clk);
      w++;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  task automatic check_drained(input string name);
    check(name, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int base_deq, base_fv, n;
    bus_if.desc_valid = 1'b0;
    bus_if.desc_dest  = '0;
    bus_if.desc_vc    = '0;
    bus_if.desc_nflit = '0;

    // reset values
    repeat (2) @(negedge clk);
    check("rst_op", {29'd0, bus_if.trf_op}, OP_NOP);
    check("rst_data", bus_if.trf_data, 32'd0);
    check("rst_ready", {31'd0, bus_if.desc_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // zero packets: straight to DONE, no commands
    pulse_start(10'd0);
    n = 0;
    while (!done && n < 2) begin
      @(negedge clk);
      n++;
    end
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_err", {31'd0, err}, 32'd0);
    check("zero_busy", {31'd0, busy}, 32'd0);

    // two packets, credits returned with each Dequeue
    auto_ret = 1'b1;
    base_deq = deq_count;
    base_fv  = fv_count;
    pulse_start(10'd2);
    check("t2_busy", {31'd0, busy}, 32'd1);
    send_desc(14'd5, 2'd1, 10'd3);
    send_desc(14'd9, 2'd0, 10'd1);
    push_run(4);
    wait_done("t2_done", 60);
    check("t2_deq", deq_count - base_deq, 32'd4);
    check("t2_fv", fv_count - base_fv, 32'd4);
    check("t2_err", {31'd0, err}, 32'd0);
    check_drained("t2_drained");

    // credit stall: 10 flits, 4 credits, then 6 returns
    auto_ret = 1'b0;
    base_deq = deq_count;
    base_fv  = fv_count;
    pulse_start(10'd1);
    send_desc(14'h3ff, 2'd3, 10'd10);
    push_run(10);
    repeat (20) @(negedge clk);
    check("t3_deq_stall", deq_count - base_deq, 32'd4);
    check("t3_stall_op", {29'd0, bus_if.trf_op}, OP_NOP);
    check("t3_busy", {31'd0, busy}, 32'd1);
    check("t3_not_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      cr_man = 1'b1;
      @(negedge clk);
      cr_man = 1'b0;
      repeat (2) @(negedge clk);
    end
    wait_done("t3_done", 40);
    check("t3_deq", deq_count - base_deq, 32'd10);
    check("t3_fv", fv_count - base_fv, 32'd10);
    check("t3_err", {31'd0, err}, 32'd0);
    check_drained("t3_drained");

    // desc_valid toggling, three descriptors
    auto_ret = 1'b1;
    pulse_start(10'd3);
    send_desc(14'd1, 2'd2, 10'd1);
    @(negedge clk);
    send_desc(14'd2, 2'd1, 10'd2);
    @(negedge clk);
    send_desc(14'd3, 2'd0, 10'd1);
    check("t4_ready_prime", {31'd0, bus_if.desc_ready}, 32'd0);
    push_run(4);
    wait_done("t4_done", 60);
    check_drained("t4_drained");

    // zero-flit descriptor
    pulse_start(10'd2);
    send_desc(14'd7, 2'd1, 10'd0);
    send_desc(14'd8, 2'd2, 10'd2);
    push_run(2);
    wait_done("t5_done", 60);
    check("t5_err", {31'd0, err}, 32'd1);
    check_drained("t5_drained");

    // credit overflow in IDLE
    auto_ret = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_err", {31'd0, err}, 32'd0);
    cr_man = 1'b1;
    @(negedge clk);
    cr_man = 1'b0;
    @(negedge clk);
    check("t5_ovf_err", {31'd0, err}, 32'd1);
    check("t5_ovf_credit", 32'(dut.credit), 32'd4);

    // reset during RUN after two Dequeues, then restart
    pulse_start(10'd1);
    send_desc(14'd4, 2'd0, 10'd5);
    push(OP_PREDEQUE, 32'd0);
    push(OP_DEQUEUE, 32'd0);
    push(OP_DEQUEUE, 32'd0);
    n = 0;
    for (int w = 0; w < 50 && n < 2; w++) begin
      @(negedge clk);
      if (bus_if.trf_op == OP_DEQUEUE) n++;
    end
    check("t6_two_deq", n, 32'd2);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_op", {29'd0, bus_if.trf_op}, OP_NOP);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_credit", 32'(dut.credit), 32'd4);
    check_drained("t6_drained");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    auto_ret = 1'b1;
    base_fv = fv_count;
    pulse_start(10'd1);
    send_desc(14'd6, 2'd3, 10'd1);
    push_run(1);
    wait_done("t6_done", 40);
    check("t6_fv", fv_count - base_fv, 32'd1);
    check("t6_err", {31'd0, err}, 32'd0);
    check_drained("t6_restart_drained");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
